inst_ram_boot: RTL
==================

# inst_ram_boot

Instruction memory with an integrated byte-stream boot loader, sitting directly upstream of the `openmips` core's instruction fetch port (`rom_ce_o` / `rom_addr_o` / `rom_data_i`). After reset it holds the core in reset while it receives a length-prefixed, checksummed program image over a valid/ready byte stream and writes it into the instruction RAM. On a good checksum it releases the core. It then serves fetches combinationally, so the core's `pc_reg` → `if_id` timing is preserved.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits. DEPTH = 2^ADDR_WIDTH words (1024 by default).

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data_i` in 8: boot stream byte.
- `rx_valid_i` in 1: `rx_data_i` is valid.
- `rx_ready_o` out 1: loader accepts a byte. A byte transfers on a rising edge with `rx_valid_i && rx_ready_o`.
- `rom_ce_i` in 1: fetch enable, driven from the core's `rom_ce_o`.
- `rom_addr_i` in 32: fetch byte address, driven from the core's `rom_addr_o`.
- `rom_data_o` out 32: instruction word, driven to the core's `rom_data_i`.
- `cpu_rst_o` out 1: reset to the core, active-high.
- `boot_done_o` out 1: image loaded and verified; core running.
- `boot_err_o` out 1: load failed; sticky until `rst`.
- `words_loaded_o` out ADDR_WIDTH+1: count of words written in the current load.

## Operation
- Stream format, in order:
  - LEN_HI byte, then LEN_LO byte. Together they form N, big-endian, 16 bits.
  - 4·N data bytes. Each word is big-endian: the first byte goes to bits 31:24.
  - One checksum byte, equal to the XOR of all data bytes. Length bytes are excluded.
- FSM states: S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERR.
- Transitions:
  - S_LEN_HI → S_LEN_LO on accept.
  - S_LEN_LO on accept:
    - N > DEPTH → S_ERR.
    - N == 0 → S_CSUM (expected checksum 0x00).
    - Otherwise → S_DATA.
  - S_DATA stays in S_DATA until the 4th byte of word N−1 is accepted, then → S_CSUM.
  - S_CSUM on accept: byte == running XOR → S_RUN; otherwise → S_ERR.
  - S_RUN and S_ERR are terminal until `rst`.
- Byte assembly in S_DATA:
  - A 2-bit byte counter and a 24-bit shift holding register assemble each word.
  - On acceptance of the 4th byte, mem[word_idx] ← {held[23:0], rx_data_i} at that same edge.
  - word_idx then increments; `words_loaded_o` = word_idx.
- `rx_ready_o` = 1 in S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM; 0 in S_RUN and S_ERR.
- Read port (combinational):
  - `rom_ce_i` = 0 → `rom_data_o` = 0x00000000.
  - Otherwise `rom_data_o` = mem[`rom_addr_i[ADDR_WIDTH+1:2]`].
  - Upper address bits and bits 1:0 are ignored, so addresses wrap modulo DEPTH words.
- Memory contents are not cleared by `rst`. Words beyond N keep their previous contents.

## Timing
- Reset values:
  - State S_LEN_HI.
  - `cpu_rst_o` = 1, `boot_done_o` = 0, `boot_err_o` = 0, `rx_ready_o` = 1, `words_loaded_o` = 0.
  - Byte counter 0, running XOR 0x00.
- Throughput: one byte per cycle. `rx_valid_i` low stalls with no state change; there is no timeout.
- Write-to-read: a word written at edge t is visible on `rom_data_o` from cycle t+1.
- Read latency: zero cycles (combinational from `rom_addr_i` and `rom_ce_i`).
- Release: `cpu_rst_o` and `boot_done_o` are registered. They change at the edge that accepts a matching checksum, so the core sees reset low from the next cycle. Its first fetch is address 0x00000000.
- Error: `boot_err_o` rises at the edge that accepts the failing LEN_LO or checksum byte. `cpu_rst_o` stays 1.
- Reset mid-load (`rst` = 1 in any state at an edge):
  - The FSM and counters return to reset values.
  - Any partially assembled word is discarded.
  - Words already written remain in memory.
- `rst` has priority over a simultaneous byte transfer; that byte is dropped.

## Test plan
- **Nominal load:** send 00 02 34 01 11 00 34 02 00 20, checksum 0x32 → `boot_done_o` = 1 and `cpu_rst_o` = 0 on the cycle after the 0x32 accept; `words_loaded_o` = 2; `rom_addr_i` 0x0 → 0x34011100; 0x4 → 0x34020020; `rx_ready_o` = 0.
- **Bad checksum:** same image with checksum 0x33 → `boot_err_o` = 1, `cpu_rst_o` = 1, `boot_done_o` = 0, `rx_ready_o` = 0; further bytes ignored.
- **Length bounds (ADDR_WIDTH = 10):** length 0x0401 → S_ERR at the edge after the LEN_LO accept, with zero data bytes taken. Length 0x0400 with 4096 bytes and correct XOR → boot done, `words_loaded_o` = 1024, `rom_addr_i` 0xFFC reads the last word.
- **Backpressure gaps:** nominal image with `rx_valid_i` toggled every other cycle and junk on `rx_data_i` while invalid → identical result to the nominal load.
- **Reset mid-DATA:** after 00 02 34 01 11 00 34 (5 data bytes), pulse `rst` → `words_loaded_o` = 0, state S_LEN_HI, mem[0] still reads 0x34011100. Then reload 00 01 AA BB CC DD, checksum 0x00 → mem[0] = 0xAABBCCDD, boot done.
- **Read port edge cases:** `rom_ce_i` = 0 → `rom_data_o` = 0x00000000. `rom_addr_i` 0x00001000 and 0x00000002 both return mem[0]. Zero-length image 00 00 00 → boot done, `words_loaded_o` = 0.

Source files
------------

// File: rtl/inst_ram_boot.sv
// Instruction RAM with a length-prefixed, XOR-checksummed byte-stream boot loader.
// Holds the core in reset until a verified image is loaded, then serves fetches combinationally.
//
// state    | meaning
// S_LEN_HI | waiting for the high byte of the word count
// S_LEN_LO | waiting for the low byte; range-checks the count
// S_DATA   | assembling big-endian words and writing them to RAM
// S_CSUM   | comparing the received checksum with the running XOR
// S_RUN    | image verified, core released
// S_ERR    | oversize image or bad checksum, core held in reset
module inst_ram_boot #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    output logic                  cpu_rst_o,
    output logic                  boot_done_o,
    output logic                  boot_err_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WORD_ONE = 1;
    localparam logic [1:0]          BYTE_ONE = 2'd1;
    localparam logic [1:0]          BYTE_LAST = 2'd3;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           hold_q, hold_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic [16:0]           len_n;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem [DEPTH];

    assign accept    = rx_valid_i && rx_ready_q;
    assign len_n     = {1'b0, len_hi_q, rx_data_i};
    assign mem_wdata = {hold_q, rx_data_i};

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        hold_d       = hold_q;
        csum_d       = csum_q;
        len_hi_d     = len_hi_q;
        word_idx_d   = word_idx_q;
        words_left_d = words_left_q;
        rx_ready_d   = rx_ready_q;
        cpu_rst_d    = cpu_rst_q;
        done_d       = done_q;
        err_d        = err_q;
        mem_we       = 1'b0;

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = rx_data_i;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_n > 17'(DEPTH)) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        rx_ready_d = 1'b0;
                    end else if (len_n == 17'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d      = S_DATA;
                        words_left_d = len_n[ADDR_WIDTH:0];
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ rx_data_i;
                    byte_cnt_d = byte_cnt_q + BYTE_ONE;
                    hold_d     = {hold_q[15:0], rx_data_i};
                    if (byte_cnt_q == BYTE_LAST) begin
                        mem_we       = 1'b1;
                        word_idx_d   = word_idx_q + WORD_ONE;
                        words_left_d = words_left_q - WORD_ONE;
                        // words_left is a down-counter; terminal count ends the data phase
                        if (words_left_q == WORD_ONE) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    rx_ready_d = 1'b0;
                    if (rx_data_i == csum_q) begin
                        state_d   = S_RUN;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LEN_HI;
            byte_cnt_q   <= '0;
            hold_q       <= '0;
            csum_q       <= '0;
            len_hi_q     <= '0;
            word_idx_q   <= '0;
            words_left_q <= '0;
            rx_ready_q   <= 1'b1;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            hold_q       <= hold_d;
            csum_q       <= csum_d;
            len_hi_q     <= len_hi_d;
            word_idx_q   <= word_idx_d;
            words_left_q <= words_left_d;
            rx_ready_q   <= rx_ready_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Contents survive rst so a reset mid-load keeps previously written words.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[word_idx_q[ADDR_WIDTH-1:0]] <= mem_wdata;
        end
    end

    assign rom_data_o = rom_ce_i ? mem[rom_addr_i[ADDR_WIDTH+1:2]] : 32'h0000_0000;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};

    assign rx_ready_o     = rx_ready_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign boot_done_o    = done_q;
    assign boot_err_o     = err_q;
    assign words_loaded_o = word_idx_q;

endmodule
